// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CHK     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    localparam logic [7:0] LOADER_START_BYTE = 8'hA5;
    localparam int         BYTES_PER_WORD    = 4;

    // A frame length is usable when it is non-zero and fits the memory window.
    function automatic logic len_ok(input logic [7:0] len, input int max_words);
        return (len != 8'd0) && (int'({24'd0, len}) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in, instruction memory write port out
interface imem_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    // Source of the byte stream and observer of memory writes.
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // The loader itself.
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - big-endian byte to 32-bit word assembler
module imem_loader_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] shift;
    logic [1:0]  count;

    // Shift accepted bytes in MSB-first; clear drops any partial word.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            shift <= '0;
            count <= '0;
        end else if (byte_valid) begin
            shift <= {shift[15:0], byte_data};
            count <= count + 2'd1;
        end
    end

    // The completing byte is merged combinationally so the word is ready the same cycle.
    assign word       = {shift, byte_data};
    assign word_valid = byte_valid && (count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte stream loader for instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W         = 16,
    parameter int         MAX_WORDS      = 32,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] START_BYTE     = LOADER_START_BYTE
)(
    input  logic           clock,
    input  logic           reset,
    imem_loader_if.slave   bus,
    input  logic           ack,
    output logic           cpu_hold,
    output logic           done,
    output logic           error,
    output logic [1:0]     err_code,
    output logic [5:0]     words_loaded
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t       state;
    logic [7:0]   len_q;
    logic [7:0]   chk_q;
    logic [TW-1:0] timer;
    logic         accept;
    logic         active;
    logic         timeout_hit;
    logic         last_word;
    logic         pk_clear;
    logic         pk_valid;
    logic         word_valid;
    logic [31:0]  word;

    assign accept      = bus.in_valid && bus.in_ready;
    assign active      = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
    // A byte arriving on the expiry cycle is processed instead of timing out.
    assign timeout_hit = active && !accept && (timer == TW'(TIMEOUT_CYCLES - 1));
    assign last_word   = (({2'b00, words_loaded} + 8'd1) == len_q);
    assign pk_clear    = (state != ST_DATA);
    assign pk_valid    = accept && (state == ST_DATA);

    imem_loader_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (bus.in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    // Inter-byte idle counter, only meaningful while a frame is open.
    always_ff @(posedge clock) begin
        if (reset || !active || accept) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Frame sequencing, checksum and memory write strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            bus.in_ready <= 1'b1;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            len_q        <= '0;
            chk_q        <= '0;
        end else begin
            bus.wr_en <= 1'b0;
            if (timeout_hit) begin
                state        <= ST_ERR;
                error        <= 1'b1;
                err_code     <= ERR_TIMEOUT;
                bus.in_ready <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept && (bus.in_data == START_BYTE)) begin
                            state        <= ST_LEN;
                            cpu_hold     <= 1'b1;
                            words_loaded <= '0;
                        end
                    end
                    ST_LEN: begin
                        if (accept) begin
                            if (!len_ok(bus.in_data, MAX_WORDS)) begin
                                state        <= ST_ERR;
                                error        <= 1'b1;
                                err_code     <= ERR_LEN;
                                bus.in_ready <= 1'b0;
                            end else begin
                                len_q <= bus.in_data;
                                chk_q <= '0;
                                state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (accept) begin
                            chk_q <= chk_q ^ bus.in_data;
                            if (word_valid) begin
                                bus.wr_en    <= 1'b1;
                                bus.wr_addr  <= ADDR_W'({words_loaded, 2'b00});
                                bus.wr_data  <= word;
                                words_loaded <= words_loaded + 6'd1;
                                if (last_word) begin
                                    state <= ST_CHK;
                                end
                            end
                        end
                    end
                    ST_CHK: begin
                        if (accept) begin
                            bus.in_ready <= 1'b0;
                            if (bus.in_data == chk_q) begin
                                state    <= ST_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
                            end else begin
                                state    <= ST_ERR;
                                error    <= 1'b1;
                                err_code <= ERR_CHK;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (ack) begin
                            state        <= ST_IDLE;
                            done         <= 1'b0;
                            bus.in_ready <= 1'b1;
                        end
                    end
                    ST_ERR: begin
                        if (ack) begin
                            state        <= ST_IDLE;
                            error        <= 1'b0;
                            err_code     <= ERR_NONE;
                            cpu_hold     <= 1'b0;
                            bus.in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int T_OUT = 60;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ack   = 1'b0;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic [5:0] words_loaded;

    imem_loader_if #(.ADDR_W(16)) bus ();

    imem_loader #(
        .ADDR_W         (16),
        .MAX_WORDS      (32),
        .TIMEOUT_CYCLES (T_OUT),
        .START_BYTE     (8'hA5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .ack          (ack),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int consec   = 0;
    logic prev_wr = 1'b0;

    logic [7:0]  frame_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Capture every write strobe and flag back-to-back strobes.
    always @(negedge clock) begin
        if (reset) begin
            prev_wr = 1'b0;
        end else begin
            if (bus.wr_en) begin
                got_addr.push_back(32'(bus.wr_addr));
                got_data.push_back(bus.wr_data);
                if (prev_wr) consec++;
            end
            prev_wr = bus.wr_en;
        end
    end

    // Reference: interpret the frame straight from the framing rules.
    task automatic model(output logic e_done, output logic e_err,
                         output logic [1:0] e_code, output logic [5:0] e_wl);
        int i = 0;
        int len;
        logic [7:0]  x = 8'h00;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        e_done = 1'b0; e_err = 1'b0; e_code = 2'd0; e_wl = 6'd0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        i++;
        len = int'(frame_q[i]);
        i++;
        if (len == 0 || len > 32) begin
            e_err = 1'b1; e_code = 2'd1;
            return;
        end
        for (int k = 0; k < len; k++) begin
            w = {frame_q[i], frame_q[i+1], frame_q[i+2], frame_q[i+3]};
            x = x ^ frame_q[i] ^ frame_q[i+1] ^ frame_q[i+2] ^ frame_q[i+3];
            exp_addr.push_back(32'(k * 4));
            exp_data.push_back(w);
            i += 4;
        end
        e_wl = 6'(len);
        if (frame_q[i] == x) e_done = 1'b1;
        else begin e_err = 1'b1; e_code = 2'd2; end
    endtask

    // Called at a falling edge; returns at the falling edge just after acceptance.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clock);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_ack(input string name);
        ack = 1'b1;
        @(negedge clock);
        ack = 1'b0;
        expect_eq({name, "_ack_status"}, {29'd0, done, error, cpu_hold}, 32'd0);
        expect_eq({name, "_ack_code"}, 32'(err_code), 32'd0);
        expect_eq({name, "_ack_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_frame(input string name, input int gap_lo, input int gap_hi);
        logic e_done, e_err;
        logic [1:0] e_code;
        logic [5:0] e_wl;
        model(e_done, e_err, e_code, e_wl);
        got_addr.delete();
        got_data.delete();
        consec = 0;
        foreach (frame_q[k]) send_byte(frame_q[k], int'($urandom_range(gap_lo, gap_hi)));
        @(negedge clock);
        expect_eq({name, "_done"}, 32'(done), 32'(e_done));
        expect_eq({name, "_error"}, 32'(error), 32'(e_err));
        expect_eq({name, "_code"}, 32'(err_code), 32'(e_code));
        expect_eq({name, "_hold"}, 32'(cpu_hold), 32'(e_err));
        expect_eq({name, "_wl"}, 32'(words_loaded), 32'(e_wl));
        expect_eq({name, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        expect_eq({name, "_consec"}, 32'(consec), 32'd0);
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            expect_eq({name, "_addr"}, got_addr[k], exp_addr[k]);
            expect_eq({name, "_data"}, got_data[k], exp_data[k]);
        end
        do_ack(name);
    endtask

    initial begin
        logic [7:0] b, x, len;
        int kind;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clock);
        expect_eq("reset_status", {28'd0, bus.wr_en, cpu_hold, done, error}, 32'd0);
        expect_eq("reset_ready", 32'(bus.in_ready), 32'd1);
        expect_eq("reset_wl", 32'(words_loaded), 32'd0);
        expect_eq("reset_addr", 32'(bus.wr_addr), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Reference frame with write latency observed directly.
        frame_q = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13, 8'h31};
        got_addr.delete(); got_data.delete();
        for (int k = 0; k < frame_q.size(); k++) begin
            send_byte(frame_q[k], 0);
            if (k == 2) expect_eq("t1_hold_mid", 32'(cpu_hold), 32'd1);
            if (k == 5) begin
                expect_eq("t1_lat_wr", 32'(bus.wr_en), 32'd1);
                expect_eq("t1_lat_addr", 32'(bus.wr_addr), 32'd0);
                expect_eq("t1_lat_data", bus.wr_data, 32'hDEADBEEF);
                expect_eq("t1_lat_wl", 32'(words_loaded), 32'd1);
            end
            if (k == 6) expect_eq("t1_pulse", 32'(bus.wr_en), 32'd0);
        end
        expect_eq("t1_done", {29'd0, done, error, cpu_hold}, 32'b100);
        expect_eq("t1_ready", 32'(bus.in_ready), 32'd0);
        expect_eq("t1_nwr", 32'(got_addr.size()), 32'd2);
        expect_eq("t1_addr1", got_addr[1], 32'd4);
        expect_eq("t1_data1", got_data[1], 32'h00000013);
        do_ack("t1");

        frame_q = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        run_frame("badchk", 0, 2);
        frame_q = '{8'hA5, 8'h00};
        run_frame("len0", 0, 2);
        frame_q = '{8'hA5, 8'h21};
        run_frame("len33", 0, 2);
        frame_q = '{8'hA5, 8'h20};
        for (int k = 0; k < 128; k++) frame_q.push_back(8'(k * 7 + 3));
        x = 8'h00;
        for (int k = 0; k < 128; k++) x = x ^ 8'(k * 7 + 3);
        frame_q.push_back(x);
        run_frame("len32", 0, 0);

        // Silence inside a frame.
        got_addr.delete(); got_data.delete();
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
        repeat (T_OUT - 2) @(negedge clock);
        expect_eq("tmo_early", 32'(error), 32'd0);
        for (int k = 0; k < 6 && !error; k++) @(negedge clock);
        expect_eq("tmo_error", 32'(error), 32'd1);
        expect_eq("tmo_code", 32'(err_code), 32'd3);
        expect_eq("tmo_hold", 32'(cpu_hold), 32'd1);
        expect_eq("tmo_nwr", 32'(got_addr.size()), 32'd0);
        do_ack("tmo");

        // Reset part way through the data bytes.
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'hDE, 0); send_byte(8'hAD, 0);
        reset = 1'b1;
        @(negedge clock);
        expect_eq("rst_status", {28'd0, bus.wr_en, cpu_hold, done, error}, 32'd0);
        expect_eq("rst_wl", 32'(words_loaded), 32'd0);
        expect_eq("rst_ready", 32'(bus.in_ready), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        frame_q = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_frame("after_rst", 0, 1);

        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13, 8'h31};
        run_frame("garbage_gap10", 10, 10);

        for (int n = 0; n < 25; n++) begin
            frame_q.delete();
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                frame_q.push_back(b);
            end
            frame_q.push_back(8'hA5);
            kind = int'($urandom_range(0, 9));
            if (kind == 0) len = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom_range(33, 255));
            else len = 8'($urandom_range(1, 6));
            frame_q.push_back(len);
            if (kind != 0) begin
                x = 8'h00;
                for (int k = 0; k < 4 * int'(len); k++) begin
                    b = 8'($urandom);
                    x = x ^ b;
                    frame_q.push_back(b);
                end
                if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
                frame_q.push_back(x);
            end
            run_frame("rand", 0, 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
